// File: rtl/mdu_unit.sv
// mdu_unit - multi-cycle multiply/divide unit with HI/LO registers.
//
// Executes mult/multu/div/divu over MULT_LAT/DIV_LAT cycles, handles
// mthi/mtlo writes and mfhi/mflo reads, and reports busy to the stall unit.
//
// Ports:
//   clk      - clock, rising edge
//   reset    - asynchronous active-low reset
//   op       - MU op: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo,
//              6 mfhi, 7 mflo, others none
//   start    - qualifies ops 0-3
//   flush    - cancels in-flight op and this cycle's op
//   src_a    - rs operand (dividend / multiplicand / mthi-mtlo source)
//   src_b    - rt operand (divisor / multiplier)
//   busy     - high while an operation is in flight
//   rd_data  - HI for op 6, LO for op 7, else 0 (combinational)
//   hi, lo   - current HI/LO registers
module mdu_unit #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXL = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           r_state, w_state_nx;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic w_accept, w_done, w_mt_ok;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nx = S_RUN;
      S_RUN:  if (flush || r_cnt == CW'(1)) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state == S_RUN);
    // op[3:2]==0 selects the four arithmetic ops
    w_accept = (r_state == S_IDLE) && start && !flush && (op[3:2] == 2'b00);
    w_done   = (r_state == S_RUN) && !flush && (r_cnt == CW'(1));
    w_mt_ok  = (r_state == S_IDLE) && !flush;
  end

  // ------------------------------------------------- operand / counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_op  <= '0;
      r_a   <= '0;
      r_b   <= '0;
    end else if (w_accept) begin
      r_cnt <= (op[1]) ? CW'(DIV_LAT) : CW'(MULT_LAT);
      r_op  <= op[1:0];
      r_a   <= src_a;
      r_b   <= src_b;
    end else if (r_state == S_RUN) begin
      r_cnt <= flush ? '0 : r_cnt - CW'(1);
    end
  end

  // ------------------------------------------------------- arithmetic
  logic signed [2*WIDTH-1:0] w_sa, w_sb, w_sprod;
  logic        [2*WIDTH-1:0] w_uprod;

  assign w_sa    = {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_sb    = {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_sprod = w_sa * w_sb;
  assign w_uprod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

  // Signed divide is done on magnitudes then re-signed; this gives
  // truncation toward zero and a remainder with the dividend's sign.
  // The -2^(W-1)/-1 case falls out naturally: magnitude quotient 2^(W-1)
  // re-negates to itself and the remainder is 0.
  logic             w_sgn, w_neg_a, w_neg_b, w_div0;
  logic [WIDTH-1:0] w_ma, w_mb, w_uq, w_ur, w_q, w_r;

  assign w_sgn   = (r_op == OP_DIV[1:0]);
  assign w_neg_a = w_sgn & r_a[WIDTH-1];
  assign w_neg_b = w_sgn & r_b[WIDTH-1];
  assign w_ma    = w_neg_a ? -r_a : r_a;
  assign w_mb    = w_neg_b ? -r_b : r_b;
  assign w_div0  = (r_b == '0);
  // Divisor forced nonzero so the divider never sees /0; result unused then.
  assign w_uq    = w_ma / (w_div0 ? {{(WIDTH-1){1'b0}}, 1'b1} : w_mb);
  assign w_ur    = w_ma % (w_div0 ? {{(WIDTH-1){1'b0}}, 1'b1} : w_mb);
  assign w_q     = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
  assign w_r     = w_neg_a ? -w_ur : w_ur;

  // ------------------------------------------------------------ HI/LO
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      case (r_op)
        OP_MULT[1:0]:  {r_hi, r_lo} <= w_sprod;
        OP_MULTU[1:0]: {r_hi, r_lo} <= w_uprod;
        default: if (!w_div0) begin
          r_hi <= w_r;
          r_lo <= w_q;
        end
      endcase
    end else if (w_mt_ok) begin
      if (op == OP_MTHI) r_hi <= src_a;
      if (op == OP_MTLO) r_lo <= src_a;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

  always_comb begin
    rd_data = '0;
    if (op == OP_MFHI) rd_data = r_hi;
    if (op == OP_MFLO) rd_data = r_lo;
  end

  // OP_DIVU only documents the encoding; it is the default branch above.
  logic w_unused;
  assign w_unused = &{1'b0, OP_DIVU};

endmodule

// File: doc/mdu_unit.md
# mdu_unit

Parametrised multi-cycle multiply/divide unit with HI/LO registers for the execute stage. It consumes the 4-bit MU operation code from the decoder and executes mult/multu/div/divu over configurable latencies. It also performs mthi/mtlo writes and mfhi/mflo reads, and exports `busy` so the stall unit can hold dependent MU instructions. A `flush` input aborts an in-flight operation on pipeline cancellation.

## Interface
- `WIDTH`, default 32: operand and HI/LO width.
- `MULT_LAT`, default 5: cycles from accepted mult/multu to HI/LO update; must be ≥1.
- `DIV_LAT`, default 10: cycles from accepted div/divu to HI/LO update; must be ≥1.
- `clk` input, 1 bit: clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `op` input, 4 bits: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo, 8 none. Values 9–15 behave as none.
- `start` input, 1 bit: qualifies ops 0–3 this cycle.
- `flush` input, 1 bit: cancel any in-flight operation and this cycle's `op`.
- `src_a` input, WIDTH bits: rs value (dividend, multiplicand, mthi/mtlo source).
- `src_b` input, WIDTH bits: rt value (divisor, multiplier).
- `busy` output, 1 bit: registered; high while an operation is in flight.
- `rd_data` output, WIDTH bits: HI for op 6, LO for op 7, else 0. Combinational from current HI/LO.
- `hi` output, WIDTH bits: current HI register.
- `lo` output, WIDTH bits: current LO register.

## Operation
- Two states, IDLE and RUN. The counter is ceil(log2(max(MULT_LAT,DIV_LAT)+1)) bits.
- In IDLE, when `start` is high, `op` is 0–3 and `flush` is low:
  - latch the operands and op;
  - load the counter with MULT_LAT or DIV_LAT;
  - go to RUN, with `busy` high from the next cycle.
- In RUN:
  - the counter decrements each cycle;
  - at counter 1, the next edge writes HI/LO, clears `busy` and returns to IDLE.
- mult: signed 2·WIDTH-bit product; {HI,LO} = product.
- multu: unsigned 2·WIDTH-bit product; {HI,LO} = product.
- div/divu:
  - LO = quotient, HI = remainder;
  - signed quotient truncates toward zero; remainder takes the sign of the dividend.
- Signed overflow (-2^(WIDTH-1) / -1): LO = -2^(WIDTH-1), HI = 0.
- Divide by zero (either sign): HI/LO unchanged at completion; `busy` timing is still normal.
- mthi/mtlo:
  - write `src_a` to HI/LO at the edge, only in IDLE with `flush` low;
  - ignored while `busy`; the stall unit guarantees they never arrive then.
- `start` with op 0–3 while busy: ignored; no state change.
- `flush`:
  - in RUN, next edge returns to IDLE, clears `busy`, leaves HI/LO untouched;
  - flush and start in the same cycle: flush wins, nothing starts;
  - flush with mthi/mtlo: write suppressed.
- `rd_data` during RUN shows the old HI/LO. The stall unit prevents mfhi/mflo issue while `busy` or `start`.

## Timing
- Reset (low, asynchronous): HI=0, LO=0, `busy`=0, state IDLE, counter 0, latched operands 0. All outputs are 0 immediately.
- Start accepted at edge T:
  - `busy`=1 for cycles T+1 … T+LAT;
  - HI/LO hold new values after edge T+LAT;
  - `busy`=0 after edge T+LAT.
- A back-to-back start is accepted at edge T+LAT+1 at the earliest, the first cycle `busy` is low.
- mthi/mtlo have 1-cycle latency: the value is visible on `hi`/`lo` after the edge.
- `rd_data` has zero latency: combinational.
- Reset asserted mid-RUN: immediate IDLE, HI/LO cleared, result discarded.
- With LAT=1, `busy` is high for exactly one cycle.

## Test plan
- Reset then `op`=0 (mult), `start`, src_a=-3, src_b=7 → `busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- `op`=3 (divu), `start`, src_a=100, src_b=7 → `busy` 10 cycles; LO=14, HI=2. Repeat with `op`=2, src_a=-7, src_b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- `op`=2 with src_a=0x80000000, src_b=0xFFFFFFFF → LO=0x80000000, HI=0. Then src_b=0 → HI/LO unchanged, `busy` still 10 cycles.
- `op`=4, src_a=0x1234 → HI=0x1234 next cycle. Then `op`=6 → `rd_data`=0x1234 same cycle.
- Start mult, assert `flush` in the 3rd busy cycle → `busy`=0 next edge, HI/LO keep the pre-start values. Flush with start in the same cycle → `busy` never rises.
- Start div, pulse `reset` low mid-RUN → `busy`, HI, LO all 0 immediately. After release, a new mult starts normally.
